dht_display: RTL and testbench

Display back-end for the DHT humidity/temperature reader in `TOP`. It sits directly downstream of the DHT bus receiver and consumes each 40-bit frame the receiver produces. It verifies the frame checksum, latches the four data bytes, and converts the selected integer byte (humidity or temperature) to BCD with a sequential double-dabble engine. It drives the 4-digit multiplexed 7-segment display and the `error` LED.

---
 rtl/dht_display.sv | 175 +++++++++++++++++
 tb/tb_dht_display.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dht_display.sv
// Display back-end for the DHT reader: checksum, byte latch, double-dabble BCD, 4-digit 7-seg scan.
// Define DHT_CHECKSUM_EN to verify the frame checksum; otherwise every frame is accepted and error stays 0.
module dht_display #(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] frame_i,
  input  logic        frame_valid_i,
  input  logic        sw_h_t_select,
  output logic        error,
  output logic [6:0]  led_7seg_o,
  output logic [3:0]  anode_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_C     = 7'b1000110;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  h_i, h_d, t_i, t_d;
  logic        have_data;
  logic        sel_q;
  logic        frame_good, frame_acc, sel_chg, trigger;
  logic [7:0]  conv_byte;
  logic [19:0] sreg;
  logic [2:0]  bit_cnt;
  logic        conv_sel;
  logic [3:0]  disp_hund, disp_tens, disp_units;
  logic        disp_sel;
  logic [CNT_W-1:0] cnt;
  logic [1:0]  idx;
  logic        unused_bits;

  // One double-dabble iteration: add 3 to any BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int n = 0; n < 3; n++) begin
      if (t[8+4*n +: 4] >= 4'd5) t[8+4*n +: 4] = t[8+4*n +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

`ifdef DHT_CHECKSUM_EN
  logic [7:0] sum;
  logic       err_q;
  assign sum        = frame_i[39:32] + frame_i[31:24] + frame_i[23:16] + frame_i[15:8];
  assign frame_good = (sum == frame_i[7:0]);
  assign error      = err_q;

  always_ff @(posedge clk) begin
    if (!rst)               err_q <= 1'b0;
    else if (frame_valid_i) err_q <= !frame_good;
  end
`else
  assign frame_good = 1'b1;
  assign error      = 1'b0;
`endif

  assign unused_bits = ^{h_d, t_d, frame_i[7:0]};

  // A select change only matters once there is data to reconvert.
  assign frame_acc = frame_valid_i && frame_good;
  assign sel_chg   = have_data && (sw_h_t_select != sel_q);
  assign trigger   = frame_acc || sel_chg;
  assign conv_byte = sw_h_t_select ? (frame_acc ? frame_i[23:16] : t_i)
                                   : (frame_acc ? frame_i[39:32] : h_i);

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_i       <= 8'd0;
      h_d       <= 8'd0;
      t_i       <= 8'd0;
      t_d       <= 8'd0;
      have_data <= 1'b0;
      sel_q     <= 1'b0;
      state     <= IDLE;
    end else begin
      sel_q <= sw_h_t_select;
      state <= state_next;
      if (frame_acc) begin
        {h_i, h_d, t_i, t_d} <= frame_i[39:8];
        have_data            <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = IDLE;
      SHIFT:   if (bit_cnt == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (trigger) state_next = SHIFT;
  end

  // Conversion datapath; a trigger always reloads, aborting any conversion in flight.
  always_ff @(posedge clk) begin
    if (trigger) begin
      sreg     <= {12'd0, conv_byte};
      conv_sel <= sw_h_t_select;
    end else if (state == SHIFT) begin
      sreg <= dd_step(sreg);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt    <= 3'd0;
      disp_hund  <= 4'd0;
      disp_tens  <= 4'd0;
      disp_units <= 4'd0;
      disp_sel   <= 1'b0;
    end else begin
      if (trigger)             bit_cnt <= 3'd0;
      else if (state == SHIFT) bit_cnt <= bit_cnt + 3'd1;
      if (state == DONE) begin
        disp_hund  <= sreg[19:16];
        disp_tens  <= sreg[15:12];
        disp_units <= sreg[11:8];
        disp_sel   <= conv_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    anode_o    = ~(4'b0001 << idx);
    led_7seg_o = SEG_DASH;
    if (have_data) begin
      case (idx)
        2'd3:    led_7seg_o = (disp_hund == 4'd0) ? SEG_BLANK : seg_digit(disp_hund);
        2'd2:    led_7seg_o = seg_digit(disp_tens);
        2'd1:    led_7seg_o = seg_digit(disp_units);
        default: led_7seg_o = disp_sel ? SEG_C : SEG_H;
      endcase
    end
  end

endmodule

// File: tb/tb_dht_display.sv
// Self-checking bench for dht_display: vector table, hand sequences and randomized traffic vs a reference model.
module tb_dht_display;
  localparam int DIV = 4;
`ifdef DHT_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [39:0] frame_i = 40'd0;
  logic        frame_valid_i = 1'b0;
  logic        sw_h_t_select = 1'b0;
  logic        error;
  logic [6:0]  led_7seg_o;
  logic [3:0]  anode_o;

  dht_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .frame_i(frame_i), .frame_valid_i(frame_valid_i),
    .sw_h_t_select(sw_h_t_select), .error(error), .led_7seg_o(led_7seg_o), .anode_o(anode_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state, expressed as time-to-completion rather than FSM states.
  bit m_err, m_have, m_sel, m_known, m_dsel, m_psel;
  int m_hi, m_ti, m_pend, m_val, m_pval, m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    return (d == 10) ? 7'h7F : seg_tab[d];
  endfunction

  function automatic int exp_led(input int pos);
    if (!m_have) return 32'h3F;
    if (!m_known) return -1;
    case (pos)
      3:       return int'(pat((m_val / 100) == 0 ? 10 : m_val / 100));
      2:       return int'(pat((m_val / 10) % 10));
      1:       return int'(pat(m_val % 10));
      default: return m_dsel ? 32'h46 : 32'h09;
    endcase
  endfunction

  task automatic model_edge();
    int s;
    bit cks_ok, good, selchg;
    if (!rst) begin
      m_err = 0; m_have = 0; m_sel = 0; m_known = 0;
      m_hi = 0; m_ti = 0; m_pend = 0; m_cnt = 0;
      return;
    end
    m_cnt++;
    if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        m_val = m_pval; m_dsel = m_psel; m_known = 1;
      end
    end
    s = int'(frame_i[39:32]) + int'(frame_i[31:24]) + int'(frame_i[23:16]) + int'(frame_i[15:8]);
    cks_ok = !CHK_EN || ((s % 256) == int'(frame_i[7:0]));
    good   = frame_valid_i && cks_ok;
    selchg = m_have && (sw_h_t_select != m_sel);
    if (good || selchg) begin
      if (good) m_pval = sw_h_t_select ? int'(frame_i[23:16]) : int'(frame_i[39:32]);
      else      m_pval = sw_h_t_select ? m_ti : m_hi;
      m_psel = sw_h_t_select;
      m_pend = 9;
    end
    if (frame_valid_i) m_err = !cks_ok;
    if (good) begin
      m_hi = int'(frame_i[39:32]); m_ti = int'(frame_i[23:16]); m_have = 1;
    end
    m_sel = sw_h_t_select;
  endtask

  task automatic tick();
    int idx, e;
    @(posedge clk);
    model_edge();
    #1;
    idx = (m_cnt / DIV) % 4;
    chk("anode", int'(anode_o), (~(1 << idx)) & 15);
    chk("error", int'(error), int'(m_err));
    e = exp_led(idx);
    if (e >= 0) chk("led", int'(led_7seg_o), e);
  endtask

  logic [6:0] got [4];

  task automatic scan_digits();
    for (int k = 0; k < 4; k++) got[k] = 7'h00;
    for (int k = 0; k < 4 * DIV; k++) begin
      tick();
      case (anode_o)
        4'b1110: got[0] = led_7seg_o;
        4'b1101: got[1] = led_7seg_o;
        4'b1011: got[2] = led_7seg_o;
        4'b0111: got[3] = led_7seg_o;
        default: ;
      endcase
    end
  endtask

  task automatic chk_digits(input string name, input int h, input int t, input int u, input bit let_c);
    scan_digits();
    chk({name, "_d3"}, int'(got[3]), int'(pat(h)));
    chk({name, "_d2"}, int'(got[2]), int'(pat(t)));
    chk({name, "_d1"}, int'(got[1]), int'(pat(u)));
    chk({name, "_d0"}, int'(got[0]), let_c ? 32'h46 : 32'h09);
  endtask

  task automatic send(input logic [39:0] f, input bit sel);
    frame_i = f; sw_h_t_select = sel; frame_valid_i = 1'b1;
    tick();
    frame_valid_i = 1'b0;
  endtask

  typedef struct {
    logic [39:0] frame;
    bit          sel;
    bit          bad;
    int          h, t, u;
    bit          let_c;
  } vec_t;

  vec_t vecs [9];
  logic [3:0] scan_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    vecs[0] = '{40'h49521B2DE3, 1'b0, 1'b0, 10, 7, 3, 1'b0};
    vecs[1] = '{40'h49521B2DE3, 1'b1, 1'b0, 10, 2, 7, 1'b1};
    vecs[2] = '{40'h49521B2DE4, 1'b1, 1'b1, 10, 2, 7, 1'b1};
    vecs[3] = '{40'h49521B2DE3, 1'b0, 1'b0, 10, 7, 3, 1'b0};
    vecs[4] = '{40'hFF01000000, 1'b0, 1'b0,  2, 5, 5, 1'b0};
    vecs[5] = '{40'h0A0063006D, 1'b1, 1'b0, 10, 9, 9, 1'b1};
    vecs[6] = '{40'h0500000005, 1'b0, 1'b0, 10, 0, 5, 1'b0};
    vecs[7] = '{40'h6400000064, 1'b0, 1'b0,  1, 0, 0, 1'b0};
    vecs[8] = '{40'h0000000000, 1'b0, 1'b0, 10, 0, 0, 1'b0};

    // Reset state
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_anode", int'(anode_o), 32'hE);
    chk("rst_led", int'(led_7seg_o), 32'h3F);
    chk("rst_error", int'(error), 0);

    // Scan rotation, then reset mid-scan
    rst = 1'b1;
    for (int t = 1; t <= 21; t++) begin
      tick();
      chk("scan_anode", int'(anode_o), int'(scan_pat[(t / DIV) % 4]));
    end
    rst = 1'b0;
    tick();
    chk("midscan_rst_anode", int'(anode_o), 32'hE);
    rst = 1'b1;
    tick();

    // Vector table
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].frame, vecs[i].sel);
      chk("tbl_error", int'(error), CHK_EN ? int'(vecs[i].bad) : 0);
      repeat (11) tick();
      chk_digits("tbl", vecs[i].h, vecs[i].t, vecs[i].u, vecs[i].let_c);
    end

    // Select change alone, then toggled back mid-conversion
    send(40'h49521B2DE3, 1'b0);
    repeat (11) tick();
    sw_h_t_select = 1'b1;
    repeat (12) tick();
    chk_digits("sel_temp", 10, 2, 7, 1'b1);
    sw_h_t_select = 1'b0;
    repeat (12) tick();
    sw_h_t_select = 1'b1;
    repeat (4) tick();
    sw_h_t_select = 1'b0;
    repeat (12) tick();
    chk_digits("sel_restart", 10, 7, 3, 1'b0);

    // New frame during SHIFT replaces the conversion in flight
    send(40'h6400000064, 1'b0);
    repeat (3) tick();
    send(40'hFF01000000, 1'b0);
    repeat (11) tick();
    chk_digits("frame_restart", 2, 5, 5, 1'b0);

    // Reset during a conversion
    send(40'h0A0063006D, 1'b1);
    repeat (4) tick();
    rst = 1'b0;
    tick();
    chk("conv_rst_led", int'(led_7seg_o), 32'h3F);
    chk("conv_rst_anode", int'(anode_o), 32'hE);
    rst = 1'b1;
    repeat (12) tick();
    chk("conv_rst_dash", int'(led_7seg_o), 32'h3F);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      frame_i = {b0, b1, b2, b3, ($urandom_range(0, 1) == 0) ? 8'(b0 + b1 + b2 + b3) : 8'($urandom)};
      frame_valid_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) sw_h_t_select = !sw_h_t_select;
      rst = ($urandom_range(0, 299) != 0);
      tick();
    end
    frame_valid_i = 1'b0;
    rst = 1'b1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
